// File: rtl/priority_arbiter_pkg.sv
// Shared types and default sizing for the priority arbiter slice.
// Optional grant watchdog is enabled by defining PRIO_ARB_TIMEOUT_EN.
package prio_arb_pkg;

   localparam int unsigned N_DEF       = 8;
   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle of the priority arbiter; master drives requests, slave is the arbiter.
interface priority_arbiter_if
   import prio_arb_pkg::*;
#(
   parameter int unsigned N = N_DEF
);
   localparam int unsigned W = $clog2(N);

   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic [N-1:0] grant;
   logic [W-1:0] grant_idx;
   logic         valid;
   logic         idle;
   logic         timeout;

   modport master (
      output req, mode, ack,
      input  grant, grant_idx, valid, idle, timeout
   );

   modport slave (
      input  req, mode, ack,
      output grant, grant_idx, valid, idle, timeout
   );

endinterface

// File: rtl/priority_arbiter_enc.sv
// Fixed-priority encoder: index of the highest set bit, plus an any-set flag.
module prio_enc #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]         in,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int unsigned W = $clog2(N);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (in[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_arbiter.sv
// Two-state priority arbiter (fixed or round-robin) with registered one-hot grant.
// Define PRIO_ARB_TIMEOUT_EN to add a grant watchdog that forces release after TIMEOUT cycles.
module priority_arbiter
   import prio_arb_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   priority_arbiter_if.slave     bus
);
   localparam int unsigned W = $clog2(N);

   state_t       state, state_nx;
   logic [W-1:0] ptr, ptr_nx;
   logic [W-1:0] idx_q, idx_nx;
   logic [N-1:0] grant_q, grant_nx;

   logic [N-1:0] above_ptr, req_rev, masked_rev;
   logic [W-1:0] fix_idx, m_idx, u_idx, rr_idx, win_idx;
   logic         fix_any, m_any, u_any;

   // Round-robin wants the lowest set index above ptr; reversing the vector lets the
   // highest-wins encoder find it, and the index is mirrored back afterwards.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         above_ptr[i]  = (W'(i) > ptr);
         req_rev[i]    = bus.req[N-1-i];
         masked_rev[i] = bus.req[N-1-i] & above_ptr[N-1-i];
      end
   end

   prio_enc #(.N(N)) u_fix   (.in(bus.req),    .idx(fix_idx), .any(fix_any));
   prio_enc #(.N(N)) u_rr_m  (.in(masked_rev), .idx(m_idx),   .any(m_any));
   prio_enc #(.N(N)) u_rr_u  (.in(req_rev),    .idx(u_idx),   .any(u_any));

   assign rr_idx  = m_any ? (W'(N-1) - m_idx) : (W'(N-1) - u_idx);
   assign win_idx = (bus.mode && u_any) ? rr_idx : fix_idx;

`ifdef PRIO_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT);
   logic [CW-1:0] wd, wd_nx;
   logic          timeout_q, timeout_nx;
`endif

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      idx_nx   = idx_q;
      grant_nx = grant_q;
`ifdef PRIO_ARB_TIMEOUT_EN
      wd_nx      = wd;
      timeout_nx = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (fix_any) begin
               state_nx = GRANT;
               idx_nx   = win_idx;
               ptr_nx   = win_idx;
               grant_nx = N'(1) << win_idx;
`ifdef PRIO_ARB_TIMEOUT_EN
               wd_nx    = '0;
`endif
            end
         end
         GRANT: begin
            if (bus.ack) begin
               state_nx = IDLE;
               idx_nx   = '0;
               grant_nx = '0;
            end
`ifdef PRIO_ARB_TIMEOUT_EN
            else if (wd == CW'(TIMEOUT-1)) begin
               state_nx   = IDLE;
               idx_nx     = '0;
               grant_nx   = '0;
               timeout_nx = 1'b1;
            end else begin
               wd_nx = wd + 1'b1;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= W'(N-1);
         idx_q   <= '0;
         grant_q <= '0;
`ifdef PRIO_ARB_TIMEOUT_EN
         wd        <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         idx_q   <= idx_nx;
         grant_q <= grant_nx;
`ifdef PRIO_ARB_TIMEOUT_EN
         wd        <= wd_nx;
         timeout_q <= timeout_nx;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.valid     = (state == GRANT);
   assign bus.idle      = (state == IDLE);
`ifdef PRIO_ARB_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8: number of request channels, N >= 2.
REQ-002 Parameter TIMEOUT, default 16: grant watchdog limit in cycles, >= 2; used only with PRIO_ARB_TIMEOUT_EN.
REQ-003 Localparam W = $clog2(N): width of the grant index.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  N  request vector; bit i = channel i requesting.
REQ-007 mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-008 ack  in  1  holder finished; releases the current grant.
REQ-009 grant  out  N  one-hot registered grant, all-zero when none.
REQ-010 grant_idx  out  W  binary index of the granted channel, 0 when none.
REQ-011 valid  out  1  high while a grant is held.
REQ-012 idle  out  1  high while no grant is held.
REQ-013 timeout  out  1  one-cycle pulse on watchdog release; constant 0 without the macro.

Function
REQ-014 Two-state FSM, IDLE and GRANT; all outputs registered.
REQ-015 IDLE: req == 0 -> stay IDLE; req != 0 -> load winner, go GRANT; grant visible 1 cycle after the sampled req.
REQ-016 Fixed mode: winner = highest set index of req.
REQ-017 Round-robin mode: search starts at ptr+1, ascends, wraps N-1 -> 0; first set bit wins.
REQ-018 ptr: W-bit register updated to the winner's index on every grant in both modes.
REQ-019 mode is sampled only in IDLE; a change during GRANT has no effect on the held grant.
REQ-020 GRANT: grant, grant_idx and valid hold constant until ack, regardless of req changes, including req dropping to 0.
REQ-021 ack high in GRANT -> next cycle IDLE with grant = 0 and idle = 1; re-arbitration needs at least one IDLE cycle.
REQ-022 ack in IDLE is ignored.
REQ-023 Invariant: valid == ~idle == |grant; grant == (1 << grant_idx) when valid.

Reset
REQ-024 rst high at an edge -> state IDLE, grant = 0, grant_idx = 0, valid = 0, idle = 1, timeout = 0, ptr = N-1, watchdog = 0.
REQ-025 rst overrides req and ack in the same cycle, including a mid-grant reset; the grant is lost without an ack.

Configuration
REQ-026 Macro PRIO_ARB_TIMEOUT_EN defined: a watchdog counts cycles in GRANT and clears on entry to GRANT.
REQ-027 With the macro, after TIMEOUT consecutive GRANT cycles without ack -> next cycle IDLE and timeout = 1 for exactly 1 cycle.
REQ-028 With the macro, ack in the final cycle takes precedence, so no timeout pulse is produced.
REQ-029 Macro undefined: no counter logic, timeout tied 0, and the grant is held until ack indefinitely.

Structure
REQ-030 Package prio_arb_pkg holds the state enum (IDLE, GRANT) and the default constants for N and TIMEOUT.
REQ-031 Sub-module prio_enc: parametrised fixed-priority N -> W encoder with an any output.
REQ-032 prio_enc is instantiated for the fixed path and for the masked and unmasked round-robin paths.

Verification
REQ-033 N=8, mode=0, req=8'b0010_1001 -> next cycle grant=8'b0010_0000, grant_idx=5, valid=1, idle=0; ack pulse -> next cycle grant=0, idle=1.
REQ-034 mode=1, req=8'hFF held, ack on each GRANT cycle -> grant_idx sequence after reset 0,1,...,7,0.
REQ-035 mode=1, ptr=6, req=8'b0010_0001 -> grant_idx=0 (wrap past 7), ptr becomes 0.
REQ-036 grant_idx=3 held, req driven 0 for 5 cycles, then ack -> grant stays 8'b0000_1000 all 5 cycles, then 0.
REQ-037 rst asserted while grant_idx=4 -> after the edge grant=0, valid=0, idle=1; next round-robin grant with req=8'hFF is index 0.
REQ-038 Macro defined, TIMEOUT=4, grant held with no ack -> after 4 GRANT cycles: grant=0 and timeout=1 for 1 cycle; ack in the 4th cycle -> timeout stays 0.
